// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 4-bit logic unit among N_REQ requesters,
// with a single-entry registered result buffer and a handshake counter.
module logic_unit_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    input  logic [2*N_REQ-1:0]   req_op,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    output logic [3:0]           resp_y,
    output logic [2:0]           resp_id,
    input  logic                 resp_ready,
    output logic [7:0]           done_cnt
);

    localparam int IDW = $clog2(N_REQ);
    localparam int unsigned NR = N_REQ;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [3:0]     resp_y_q, resp_y_d;
    logic [2:0]     resp_id_q, resp_id_d;
    logic [7:0]     done_cnt_q, done_cnt_d;

    logic [3:0]     a_arr  [N_REQ];
    logic [3:0]     b_arr  [N_REQ];
    logic [1:0]     op_arr [N_REQ];

    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           grant_valid;
    logic           can_accept;
    logic           transfer;
    logic [3:0]     sel_a, sel_b, unit_y;
    logic [1:0]     sel_op;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[4*i +: 4];
        assign b_arr[i]  = req_b[4*i +: 4];
        assign op_arr[i] = req_op[2*i +: 2];
    end

    // Search begins one past the last grant so the previous winner has lowest priority.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = IDW'((32'(last_grant_q) + k) % NR);
            if (!grant_valid && req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign can_accept = (state_q == EMPTY) || resp_ready;
    assign transfer   = grant_valid && can_accept;

    // Gated by areset_n so no requester sees an accept while reset is held.
    always_comb begin
        req_ready = '0;
        if (areset_n && transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a  = a_arr[grant_idx];
        sel_b  = b_arr[grant_idx];
        sel_op = op_arr[grant_idx];
        case (sel_op)
            2'b00:   unit_y = sel_a & sel_b;
            2'b01:   unit_y = sel_a | sel_b;
            2'b10:   unit_y = sel_a ^ sel_b;
            default: unit_y = ~sel_a;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        resp_y_d     = resp_y_q;
        resp_id_d    = resp_id_q;
        done_cnt_d   = done_cnt_q;

        case (state_q)
            EMPTY: begin
                if (transfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (transfer) begin
                    state_d = FULL;
                end else if (resp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (transfer) begin
            last_grant_d = grant_idx;
            resp_y_d     = unit_y;
            resp_id_d    = 3'(grant_idx);
        end

        if ((state_q == FULL) && resp_ready) begin
            done_cnt_d = done_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= EMPTY;
            last_grant_q <= IDW'(N_REQ - 1);
            resp_y_q     <= '0;
            resp_id_q    <= '0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            resp_y_q     <= resp_y_d;
            resp_id_q    <= resp_id_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign resp_valid = (state_q == FULL);
    assign resp_y     = resp_y_q;
    assign resp_id    = resp_id_q;
    assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, grant order, back-pressure,
// reset while full, back-to-back single requester and done_cnt wrap.
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        areset_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [7:0]  req_op = '0;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [3:0]  resp_y;
    logic [2:0]  resp_id;
    logic        resp_ready = 1'b0;
    logic [7:0]  done_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [3:0] y_tab [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011};
    int unsigned id_seq [5] = '{0, 1, 2, 3, 0};

    logic_unit_arbiter #(.N_REQ(4)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_y     (resp_y),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_op[2*i +: 2] = op;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        #2;
        @(negedge clk);
        areset_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) set_req(i, 4'b1100, 4'b1010, 2'(i));

        // Reset values, and no accept while reset held even with requests
        #1;
        areset_n  = 1'b0;
        req_valid = 4'b1111;
        #3;
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_y",     32'(resp_y),     32'd0);
        check_eq("rst_resp_id",    32'(resp_id),    32'd0);
        check_eq("rst_done_cnt",   32'(done_cnt),   32'd0);
        check_eq("rst_req_ready",  32'(req_ready),  32'd0);
        req_valid = '0;
        @(negedge clk);
        areset_n = 1'b1;

        // Single AND request, first edge after release
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        #1;
        check_eq("t1_req_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        check_eq("t1_resp_valid", 32'(resp_valid), 32'd1);
        check_eq("t1_resp_y",     32'(resp_y),     32'b1000);
        check_eq("t1_resp_id",    32'(resp_id),    32'd0);
        check_eq("t1_done_pre",   32'(done_cnt),   32'd0);
        tick();
        check_eq("t1_done_post",  32'(done_cnt),   32'd1);
        check_eq("t1_drained",    32'(resp_valid), 32'd0);

        // Round robin with all four requesting, one result per cycle
        do_reset();
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(4'b0001 << id_seq[k]));
            tick();
            check_eq($sformatf("rr%0d_id", k), 32'(resp_id), 32'(id_seq[k]));
            check_eq($sformatf("rr%0d_y", k),  32'(resp_y),  32'(y_tab[id_seq[k]]));
        end
        check_eq("rr_done", 32'(done_cnt), 32'd4);

        // Back-pressure: hold result, no accepts, counter frozen
        resp_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
            tick();
            check_eq($sformatf("bp%0d_y", k),    32'(resp_y),     32'b1000);
            check_eq($sformatf("bp%0d_id", k),   32'(resp_id),    32'd0);
            check_eq($sformatf("bp%0d_done", k), 32'(done_cnt),   32'd4);
            check_eq($sformatf("bp%0d_vld", k),  32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(req_ready), 32'b0010);
        tick();
        check_eq("bp_release_done", 32'(done_cnt),   32'd5);
        check_eq("bp_release_id",   32'(resp_id),    32'd1);
        check_eq("bp_release_y",    32'(resp_y),     32'b1110);
        check_eq("bp_release_vld",  32'(resp_valid), 32'd1);

        // Reset while FULL and stalled; then 0 beats 3 after release
        resp_ready = 1'b0;
        req_valid  = 4'b1001;
        #1;
        areset_n = 1'b0;
        #1;
        check_eq("mid_rst_vld",  32'(resp_valid), 32'd0);
        check_eq("mid_rst_done", 32'(done_cnt),   32'd0);
        check_eq("mid_rst_y",    32'(resp_y),     32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        #1;
        check_eq("mid_rst_ready", 32'(req_ready), 32'b0001);
        tick();
        check_eq("mid_rst_id", 32'(resp_id), 32'd0);
        check_eq("mid_rst_y2", 32'(resp_y),  32'b1000);

        // Lone requester granted every cycle
        req_valid  = 4'b0100;
        resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("solo%0d_ready", k), 32'(req_ready), 32'b0100);
            tick();
            check_eq($sformatf("solo%0d_id", k), 32'(resp_id), 32'd2);
            check_eq($sformatf("solo%0d_y", k),  32'(resp_y),  32'b0110);
        end

        // Idle cycles keep last result and last_grant
        req_valid = '0;
        tick();
        check_eq("idle_vld", 32'(resp_valid), 32'd0);
        check_eq("idle_id",  32'(resp_id),    32'd2);
        check_eq("idle_y",   32'(resp_y),     32'b0110);
        tick();
        req_valid = 4'b1111;
        #1;
        check_eq("idle_next_ready", 32'(req_ready), 32'b1000);
        tick();
        check_eq("idle_next_id", 32'(resp_id), 32'd3);
        check_eq("idle_next_y",  32'(resp_y),  32'b0011);

        // done_cnt reaches 255 then wraps to 0
        do_reset();
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        repeat (256) tick();
        check_eq("wrap_255", 32'(done_cnt), 32'd255);
        tick();
        check_eq("wrap_0",   32'(done_cnt), 32'd0);
        check_eq("wrap_vld", 32'(resp_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
